axi_master_bist: RTL and testbench
==================================

# axi_master_bist

Self-checking AXI4 master that exercises one slave port of the lab AXI interconnect. A single `start` pulse issues one INCR write burst of a known data pattern, waits for the write response, reads the same region back as one INCR burst, and compares every beat. The block is the initiator-side counterpart of the slave ports on the bus. It also serves as the bring-up and simulation traffic source for any new slave.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_1000: byte address of the first beat; 4-byte aligned.
- `BURST_LEN`, 8'd15: AXI LEN value, giving LEN+1 beats, range 0..255.
- `MASTER_ID`, 4'h0: ID driven on both address channels.
- `PATTERN_SEED`, 32'hA5A5_0000: data of beat 0; beat k carries SEED+k, modulo 2^32.

Ports:
- `clk` in 1: single clock for all logic.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `busy` out 1: high from the cycle after an accepted `start` until DONE is entered.
- `done` out 1: one-cycle pulse on entry to DONE.
- `err_cnt` out 16: mismatch and error count, saturating at 16'hFFFF; cleared on accepted `start`.
- `timeout` out 1: watchdog abort flag (see Configuration).
- `MASTER_CLK` out 1 = `clk`; `MASTER_RSTN` out 1 = ~`rst`.
- Write address channel: `MASTER_WR_ADDR_ID` out 4, `MASTER_WR_ADDR` out 32, `MASTER_WR_ADDR_LEN` out 8, `MASTER_WR_ADDR_BURST` out 2, `MASTER_WR_ADDR_VALID` out 1, `MASTER_WR_ADDR_READY` in 1.
- Write data channel: `MASTER_WR_DATA` out 32, `MASTER_WR_STRB` out 4, `MASTER_WR_DATA_LAST` out 1, `MASTER_WR_DATA_VALID` out 1, `MASTER_WR_DATA_READY` in 1.
- Write response channel: `MASTER_WR_BACK_ID` in 4, `MASTER_WR_BACK_RESP` in 2, `MASTER_WR_BACK_VALID` in 1, `MASTER_WR_BACK_READY` out 1.
- Read address channel: `MASTER_RD_ADDR_ID` out 4, `MASTER_RD_ADDR` out 32, `MASTER_RD_ADDR_LEN` out 8, `MASTER_RD_ADDR_BURST` out 2, `MASTER_RD_ADDR_VALID` out 1, `MASTER_RD_ADDR_READY` in 1.
- Read data channel: `MASTER_RD_BACK_ID` in 4, `MASTER_RD_DATA` in 32, `MASTER_RD_DATA_RESP` in 2, `MASTER_RD_DATA_LAST` in 1, `MASTER_RD_DATA_VALID` in 1, `MASTER_RD_DATA_READY` out 1.

## Operation
- States: IDLE → WA → WD → WB → RA → RD → DONE → IDLE.
- IDLE: `start`=1 clears `err_cnt`, the beat counter and `timeout`, then moves to WA.
- WA: `WR_ADDR_VALID`=1, ADDR=`BASE_ADDR`, LEN=`BURST_LEN`, BURST=2'b01, ID=`MASTER_ID`. On VALID&READY, move to WD.
- WD: `WR_DATA_VALID`=1, DATA=SEED+beat, STRB=4'hF.
  - LAST=1 when beat==`BURST_LEN`.
  - Each handshake increments beat. The handshake with LAST set moves to WB and resets beat to 0.
- WB: `WR_BACK_READY`=1. On handshake:
  - RESP ∈ {2'b10, 2'b11} → err_cnt+1.
  - BACK_ID≠`MASTER_ID` → err_cnt+1.
  - Both faults on the same response count +1 only.
  - Then move to RA.
- RA: same fields as WA on the read channel. Handshake moves to RD.
- RD: `RD_DATA_READY`=1. Each handshake compares DATA with SEED+beat. Any one or more of the following adds +1 per beat:
  - data mismatch;
  - RESP[1]=1;
  - LAST≠(beat==`BURST_LEN`).
  - Exit to DONE on the beat where LAST=1 or beat==`BURST_LEN`, whichever comes first.
- DONE: pulse `done` for one cycle, then return to IDLE. Pass is `err_cnt`==0.
- `start` outside IDLE is ignored.
- Reset values: all VALID/READY outputs 0, all address/data/ID/LEN/BURST/STRB/LAST outputs 0, `busy`=0, `done`=0, `err_cnt`=0, `timeout`=0, state IDLE.
- `rst` mid-transaction aborts immediately to the reset values. Completing the slave's outstanding burst is the system's responsibility.

## Timing
- All outputs are registered. No combinational path from any READY or VALID input to any output.
- A VALID rises the cycle after its state is entered. It stays high with stable payload until the handshake.
- Handshakes:
  - WD: back-to-back beats at 1 beat/cycle while READY=1; next data presented the cycle after each handshake.
  - WB/RD: READY high for the whole state, so throughput is 1 beat/cycle.
- Minimum latency from `start` to `done`, with all READY/VALID from the slave held high: 2×(LEN+1)+7 cycles.
- `err_cnt` updates the cycle after the offending handshake. A comparison on the final beat is visible when `done` is high.

## Configuration
- `AXI_BIST_TIMEOUT_EN` defined:
  - A 12-bit stall counter runs in WA/WD/WB/RA/RD. It clears on every handshake and on state change.
  - At 4095 stall cycles: drop all VALID/READY, set `timeout`=1 (held until the next accepted `start`), err_cnt+1, go to DONE.
- Not defined: no counter; the FSM waits indefinitely and `timeout` is tied to 0.

## Test plan
- Ideal slave, zero wait states, LEN=3, SEED=32'hA5A5_0000 → writes 0xA5A50000..0xA5A50003 with LAST on the 4th beat; reads match; `err_cnt`=0; `done` at cycle 15 after `start`.
- Random READY/VALID stalls (50%), LEN=15 → payload stable across every stall; `err_cnt`=0.
- Slave corrupts read beat 2 to 0 and returns WR RESP=2'b10 → `err_cnt`=2.
- Slave asserts RD LAST on beat 1 with LEN=3 → +1 error, early exit to DONE; `err_cnt`=1.
- `rst` pulsed mid-WD, then `start` again → all outputs at reset values the cycle after `rst`; the second run passes. A `start` pulse while busy is ignored.
- With `AXI_BIST_TIMEOUT_EN`, WR_ADDR_READY held at 0 → `timeout`=1, `err_cnt`=1, `done` 4096 cycles after WA_VALID rises.

Source files
------------

// File: rtl/axi_master_bist.sv
// axi_master_bist: self-checking AXI4 initiator. One start pulse writes an INCR
// burst of SEED+k, waits for BRESP, reads the burst back and counts mismatches.
// Latency: start->done = 2*(LEN+1)+7 cycles with a zero-wait slave; payload held until handshake.
// Ports: clk/rst (sync, active-high), start/busy/done/err_cnt/timeout status,
//        MASTER_CLK/MASTER_RSTN passthrough, AXI4 AW/W/B/AR/R channels (32-bit data, 4-bit ID).
// Option: define AXI_BIST_TIMEOUT_EN to enable the 4095-cycle stall watchdog.
module axi_master_bist #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter logic [7:0]  BURST_LEN    = 8'd15,
  parameter logic [3:0]  MASTER_ID    = 4'h0,
  parameter logic [31:0] PATTERN_SEED = 32'hA5A5_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] err_cnt,
  output logic        timeout,
  output logic        MASTER_CLK,
  output logic        MASTER_RSTN,
  output logic [3:0]  MASTER_WR_ADDR_ID,
  output logic [31:0] MASTER_WR_ADDR,
  output logic [7:0]  MASTER_WR_ADDR_LEN,
  output logic [1:0]  MASTER_WR_ADDR_BURST,
  output logic        MASTER_WR_ADDR_VALID,
  input  logic        MASTER_WR_ADDR_READY,
  output logic [31:0] MASTER_WR_DATA,
  output logic [3:0]  MASTER_WR_STRB,
  output logic        MASTER_WR_DATA_LAST,
  output logic        MASTER_WR_DATA_VALID,
  input  logic        MASTER_WR_DATA_READY,
  input  logic [3:0]  MASTER_WR_BACK_ID,
  input  logic [1:0]  MASTER_WR_BACK_RESP,
  input  logic        MASTER_WR_BACK_VALID,
  output logic        MASTER_WR_BACK_READY,
  output logic [3:0]  MASTER_RD_ADDR_ID,
  output logic [31:0] MASTER_RD_ADDR,
  output logic [7:0]  MASTER_RD_ADDR_LEN,
  output logic [1:0]  MASTER_RD_ADDR_BURST,
  output logic        MASTER_RD_ADDR_VALID,
  input  logic        MASTER_RD_ADDR_READY,
  input  logic [3:0]  MASTER_RD_BACK_ID,
  input  logic [31:0] MASTER_RD_DATA,
  input  logic [1:0]  MASTER_RD_DATA_RESP,
  input  logic        MASTER_RD_DATA_LAST,
  input  logic        MASTER_RD_DATA_VALID,
  output logic        MASTER_RD_DATA_READY
);

  typedef enum logic [2:0] {
    S_IDLE, S_WA, S_WD, S_WB, S_RA, S_RD, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  beat_q, beat_d;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic        start_ok, last_beat, abort, err_inc;
  logic        aw_vld_d, w_vld_d, ar_vld_d;
  logic [31:0] exp_dat;

  // RID and the low RESP bits carry no pass/fail information for this test.
  logic unused_inputs;
  assign unused_inputs = ^{MASTER_RD_BACK_ID, MASTER_RD_DATA_RESP[0], MASTER_WR_BACK_RESP[0]};

  assign MASTER_CLK  = clk;
  assign MASTER_RSTN = ~rst;

  assign aw_hs     = MASTER_WR_ADDR_VALID & MASTER_WR_ADDR_READY;
  assign w_hs      = MASTER_WR_DATA_VALID & MASTER_WR_DATA_READY;
  assign b_hs      = MASTER_WR_BACK_READY & MASTER_WR_BACK_VALID;
  assign ar_hs     = MASTER_RD_ADDR_VALID & MASTER_RD_ADDR_READY;
  assign r_hs      = MASTER_RD_DATA_READY & MASTER_RD_DATA_VALID;
  assign start_ok  = (state_q == S_IDLE) & start;
  assign last_beat = (beat_q == BURST_LEN);
  assign exp_dat   = PATTERN_SEED + {24'd0, beat_q};

`ifdef AXI_BIST_TIMEOUT_EN
  // Counts only cycles where this master is offering a transfer the slave
  // has not taken, so the first cycle of WA/RA (VALID not yet up) is free.
  logic [11:0] stall_q;
  logic        stalled;
  assign stalled = (MASTER_WR_ADDR_VALID & ~MASTER_WR_ADDR_READY)
                 | (MASTER_WR_DATA_VALID & ~MASTER_WR_DATA_READY)
                 | (MASTER_WR_BACK_READY & ~MASTER_WR_BACK_VALID)
                 | (MASTER_RD_ADDR_VALID & ~MASTER_RD_ADDR_READY)
                 | (MASTER_RD_DATA_READY & ~MASTER_RD_DATA_VALID);
  assign abort = stalled & (stall_q == 12'hFFF);

  always_ff @(posedge clk) begin
    if (rst || (state_d != state_q) || aw_hs || w_hs || b_hs || ar_hs || r_hs)
      stall_q <= '0;
    else if (stalled)
      stall_q <= stall_q + 12'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)           timeout <= 1'b0;
    else if (start_ok) timeout <= 1'b0;
    else if (abort)    timeout <= 1'b1;
  end
`else
  assign abort   = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_WA;
      S_WA:   if (aw_hs) state_d = S_WD;
      S_WD:   if (w_hs && MASTER_WR_DATA_LAST) state_d = S_WB;
      S_WB:   if (b_hs) state_d = S_RA;
      S_RA:   if (ar_hs) state_d = S_RD;
      // Early LAST from the slave ends the read; the LAST check below scores it.
      S_RD:   if (r_hs && (MASTER_RD_DATA_LAST || last_beat)) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_DONE;

    beat_d = beat_q;
    if (start_ok) beat_d = '0;
    if (w_hs)     beat_d = MASTER_WR_DATA_LAST ? 8'd0 : beat_q + 8'd1;
    if (r_hs)     beat_d = (state_d == S_DONE) ? 8'd0 : beat_q + 8'd1;
    if (abort)    beat_d = '0;

    // VALIDs rise one cycle after state entry and drop on the leaving edge.
    aw_vld_d = (state_q == S_WA) && (state_d == S_WA);
    w_vld_d  = (state_q == S_WD) && (state_d == S_WD);
    ar_vld_d = (state_q == S_RA) && (state_d == S_RA);

    // A bad B response counts once even if both RESP and ID are wrong.
    err_inc = abort
            | (b_hs & (MASTER_WR_BACK_RESP[1] | (MASTER_WR_BACK_ID != MASTER_ID)))
            | (r_hs & ((MASTER_RD_DATA != exp_dat) | MASTER_RD_DATA_RESP[1]
                       | (MASTER_RD_DATA_LAST != last_beat)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q               <= '0;
      err_cnt              <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      MASTER_WR_ADDR_VALID <= 1'b0;
      MASTER_WR_ADDR_ID    <= '0;
      MASTER_WR_ADDR       <= '0;
      MASTER_WR_ADDR_LEN   <= '0;
      MASTER_WR_ADDR_BURST <= '0;
      MASTER_WR_DATA_VALID <= 1'b0;
      MASTER_WR_DATA       <= '0;
      MASTER_WR_STRB       <= '0;
      MASTER_WR_DATA_LAST  <= 1'b0;
      MASTER_WR_BACK_READY <= 1'b0;
      MASTER_RD_ADDR_VALID <= 1'b0;
      MASTER_RD_ADDR_ID    <= '0;
      MASTER_RD_ADDR       <= '0;
      MASTER_RD_ADDR_LEN   <= '0;
      MASTER_RD_ADDR_BURST <= '0;
      MASTER_RD_DATA_READY <= 1'b0;
    end else begin
      beat_q <= beat_d;
      if (start_ok)
        err_cnt <= '0;
      else if (err_inc && (err_cnt != 16'hFFFF))
        err_cnt <= err_cnt + 16'd1;

      busy <= (state_d != S_IDLE) && (state_d != S_DONE);
      done <= (state_d == S_DONE) && (state_q != S_DONE);

      MASTER_WR_ADDR_VALID <= aw_vld_d;
      MASTER_WR_ADDR_ID    <= aw_vld_d ? MASTER_ID : 4'h0;
      MASTER_WR_ADDR       <= aw_vld_d ? BASE_ADDR : 32'h0;
      MASTER_WR_ADDR_LEN   <= aw_vld_d ? BURST_LEN : 8'h0;
      MASTER_WR_ADDR_BURST <= aw_vld_d ? 2'b01 : 2'b00;

      MASTER_WR_DATA_VALID <= w_vld_d;
      MASTER_WR_DATA       <= w_vld_d ? PATTERN_SEED + {24'd0, beat_d} : 32'h0;
      MASTER_WR_STRB       <= w_vld_d ? 4'hF : 4'h0;
      MASTER_WR_DATA_LAST  <= w_vld_d && (beat_d == BURST_LEN);

      MASTER_WR_BACK_READY <= (state_d == S_WB);

      MASTER_RD_ADDR_VALID <= ar_vld_d;
      MASTER_RD_ADDR_ID    <= ar_vld_d ? MASTER_ID : 4'h0;
      MASTER_RD_ADDR       <= ar_vld_d ? BASE_ADDR : 32'h0;
      MASTER_RD_ADDR_LEN   <= ar_vld_d ? BURST_LEN : 8'h0;
      MASTER_RD_ADDR_BURST <= ar_vld_d ? 2'b01 : 2'b00;

      MASTER_RD_DATA_READY <= (state_d == S_RD);
    end
  end

endmodule

// File: tb/tb_axi_master_bist.sv
// Directed bench for axi_master_bist with a reactive AXI slave model.
// Slave inputs change on the falling edge; handshakes are recorded on the rising edge.
module tb_axi_master_bist;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [7:0]  LEN  = 8'd3;
  localparam logic [3:0]  ID   = 4'h3;
  localparam logic [31:0] SEED = 32'hA5A5_0000;
  localparam int          NB   = 4;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic busy, done, timeout, m_clk, m_rstn;
  logic [15:0] err_cnt;
  logic [3:0]  aw_id, ar_id, b_id, r_id;
  logic [31:0] aw_addr, ar_addr, w_dat, r_dat;
  logic [7:0]  aw_len, ar_len;
  logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
  logic [3:0]  w_strb;
  logic aw_vld, aw_rdy, w_vld, w_rdy, w_last, b_vld, b_rdy;
  logic ar_vld, ar_rdy, r_vld, r_rdy, r_last;

  always #5 clk = ~clk;

  axi_master_bist #(.BASE_ADDR(BASE), .BURST_LEN(LEN), .MASTER_ID(ID), .PATTERN_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err_cnt(err_cnt),
    .timeout(timeout), .MASTER_CLK(m_clk), .MASTER_RSTN(m_rstn),
    .MASTER_WR_ADDR_ID(aw_id), .MASTER_WR_ADDR(aw_addr), .MASTER_WR_ADDR_LEN(aw_len),
    .MASTER_WR_ADDR_BURST(aw_burst), .MASTER_WR_ADDR_VALID(aw_vld), .MASTER_WR_ADDR_READY(aw_rdy),
    .MASTER_WR_DATA(w_dat), .MASTER_WR_STRB(w_strb), .MASTER_WR_DATA_LAST(w_last),
    .MASTER_WR_DATA_VALID(w_vld), .MASTER_WR_DATA_READY(w_rdy),
    .MASTER_WR_BACK_ID(b_id), .MASTER_WR_BACK_RESP(b_resp), .MASTER_WR_BACK_VALID(b_vld),
    .MASTER_WR_BACK_READY(b_rdy),
    .MASTER_RD_ADDR_ID(ar_id), .MASTER_RD_ADDR(ar_addr), .MASTER_RD_ADDR_LEN(ar_len),
    .MASTER_RD_ADDR_BURST(ar_burst), .MASTER_RD_ADDR_VALID(ar_vld), .MASTER_RD_ADDR_READY(ar_rdy),
    .MASTER_RD_BACK_ID(r_id), .MASTER_RD_DATA(r_dat), .MASTER_RD_DATA_RESP(r_resp),
    .MASTER_RD_DATA_LAST(r_last), .MASTER_RD_DATA_VALID(r_vld), .MASTER_RD_DATA_READY(r_rdy)
  );

  int tests = 0;
  int fails = 0;

  // Slave behaviour knobs, written only by the stimulus block.
  bit          stall_mode  = 1'b0;
  bit          hold_aw     = 1'b0;
  int          corrupt_beat = -1;
  int          early_last  = -1;
  logic [1:0]  bresp_val   = 2'b00;
  logic [3:0]  bid_val     = ID;

  // Slave state, written only by the rising-edge monitor.
  logic [31:0] mem [0:255];
  logic [31:0] wcap [0:15];
  logic        wlcap [0:15];
  logic [3:0]  wscap [0:15];
  logic [45:0] cap_aw = '0, cap_ar = '0;
  logic [45:0] aw_hold = '0, ar_hold = '0;
  logic [36:0] w_hold = '0;
  bit aw_arm = 0, w_arm = 0, ar_arm = 0, b_pend = 0, r_pend = 0;
  int widx = 0, ridx = 0, r_seq = 0, stab_err = 0;
  int r_seen = 0;

  function automatic bit coin();
    if (stall_mode) return ($urandom_range(1, 0) == 1);
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      widx = 0; ridx = 0; b_pend = 0; r_pend = 0;
      aw_arm = 0; w_arm = 0; ar_arm = 0;
    end else begin
      if (aw_arm && aw_vld && ({aw_id, aw_burst, aw_len, aw_addr} !== aw_hold)) stab_err++;
      if (w_arm && w_vld && ({w_last, w_strb, w_dat} !== w_hold)) stab_err++;
      if (ar_arm && ar_vld && ({ar_id, ar_burst, ar_len, ar_addr} !== ar_hold)) stab_err++;
      aw_arm = aw_vld && !aw_rdy;  aw_hold = {aw_id, aw_burst, aw_len, aw_addr};
      w_arm  = w_vld && !w_rdy;    w_hold  = {w_last, w_strb, w_dat};
      ar_arm = ar_vld && !ar_rdy;  ar_hold = {ar_id, ar_burst, ar_len, ar_addr};
      if (aw_vld && aw_rdy) cap_aw = {aw_id, aw_burst, aw_len, aw_addr};
      if (w_vld && w_rdy) begin
        if (widx < 16) begin wcap[widx] = w_dat; wlcap[widx] = w_last; wscap[widx] = w_strb; end
        if (widx < 256) mem[widx] = w_dat;
        widx++;
        if (w_last) begin b_pend = 1; widx = 0; end
      end
      if (b_vld && b_rdy) b_pend = 0;
      if (ar_vld && ar_rdy) begin r_pend = 1; ridx = 0; cap_ar = {ar_id, ar_burst, ar_len, ar_addr}; end
      if (r_vld && r_rdy) begin
        r_seq++;
        if (r_last) r_pend = 0; else ridx++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      aw_rdy = 0; w_rdy = 0; ar_rdy = 0; b_vld = 0; b_id = 0; b_resp = 0;
      r_vld = 0; r_last = 0; r_dat = 0; r_id = 0; r_resp = 0; r_seen = r_seq;
    end else begin
      aw_rdy = !hold_aw && coin();
      w_rdy  = coin();
      ar_rdy = coin();
      b_id   = bid_val;
      b_resp = bresp_val;
      if (!b_pend) b_vld = 0;
      else if (!b_vld) b_vld = coin();
      if (!r_pend) begin
        r_vld = 0; r_last = 0;
      end else if (!r_vld || (r_seq != r_seen)) begin
        r_vld  = coin();
        r_id   = ID;
        r_resp = 2'b00;
        r_dat  = (ridx == corrupt_beat) ? 32'h0 : mem[ridx];
        r_last = (ridx == int'(LEN)) || (ridx == early_last);
      end
      r_seen = r_seq;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_bist(input int again_at, input int max_cyc, output int cyc, output logic busy1);
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    busy1 = 1'bx;
    while (cyc < max_cyc && done !== 1'b1) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) busy1 = busy;
      start = (cyc == again_at);
    end
    start = 1'b0;
    check("done_reached", {31'd0, done}, 32'd1);
  endtask

  task automatic check_writes(input string tag);
    for (int i = 0; i < NB; i++) begin
      check({tag, "_wdat"}, wcap[i], SEED + 32'(i));
      check({tag, "_wlast"}, {31'd0, wlcap[i]}, {31'd0, (i == NB - 1)});
    end
    check({tag, "_wstrb"}, {28'd0, wscap[0]}, 32'hF);
    check({tag, "_aw"}, cap_aw[31:0], BASE);
    check({tag, "_aw_ctl"}, {18'd0, cap_aw[45:32]}, {18'd0, ID, 2'b01, LEN});
    check({tag, "_ar"}, cap_ar[31:0], BASE);
    check({tag, "_ar_ctl"}, {18'd0, cap_ar[45:32]}, {18'd0, ID, 2'b01, LEN});
  endtask

  initial begin
    int cyc, n, base_stab;
    logic b1;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_err", {16'd0, err_cnt}, 0);
    check("rst_timeout", {31'd0, timeout}, 0);
    check("rst_valids", {27'd0, aw_vld, w_vld, b_rdy, ar_vld, r_rdy}, 0);
    check("rst_payload", aw_addr | w_dat | ar_addr, 0);
    check("rst_rstn", {31'd0, m_rstn}, 0);
    check("clk_mirror", {31'd0, m_clk}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rstn_release", {31'd0, m_rstn}, 1);

    // Ideal slave: 2*(3+1)+7 = 15 cycles start->done
    run_bist(0, 3000, cyc, b1);
    check("ideal_latency", cyc, 15);
    check("ideal_busy1", {31'd0, b1}, 1);
    check("ideal_err", {16'd0, err_cnt}, 0);
    check("ideal_busy_at_done", {31'd0, busy}, 0);
    check_writes("ideal");
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 0);

    // Random stalls on every slave-driven VALID/READY
    stall_mode = 1'b1;
    base_stab = stab_err;
    run_bist(0, 3000, cyc, b1);
    check("stall_err", {16'd0, err_cnt}, 0);
    check("stall_stable", stab_err - base_stab, 0);
    check_writes("stall");
    stall_mode = 1'b0;

    // Corrupt read beat 2 and return SLVERR on B: two errors
    corrupt_beat = 2; bresp_val = 2'b10;
    run_bist(0, 3000, cyc, b1);
    check("corrupt_err", {16'd0, err_cnt}, 2);
    corrupt_beat = -1; bresp_val = 2'b00;

    // Wrong BID together with DECERR: one error for the response
    bid_val = 4'h5; bresp_val = 2'b11;
    run_bist(0, 3000, cyc, b1);
    check("bresp_bid_err", {16'd0, err_cnt}, 1);
    bid_val = ID; bresp_val = 2'b00;

    // Early RLAST on beat 1: one error, read ends two beats early
    early_last = 1;
    run_bist(0, 3000, cyc, b1);
    check("early_last_err", {16'd0, err_cnt}, 1);
    check("early_last_latency", cyc, 13);
    early_last = -1;

    // Reset in the middle of the write data phase
    @(negedge clk);
    start = 1'b1;
    n = 0;
    do begin @(negedge clk); start = 1'b0; n++; end while (w_vld !== 1'b1 && n < 20);
    check("mid_wd_reached", {31'd0, w_vld}, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_valids", {27'd0, aw_vld, w_vld, b_rdy, ar_vld, r_rdy}, 0);
    check("abort_wpayload", w_dat | {27'd0, w_strb, w_last}, 0);
    check("abort_status", {29'd0, busy, done, timeout}, 0);
    check("abort_err", {16'd0, err_cnt}, 0);
    rst = 1'b0;

    // Rerun with a stray start while busy: it must not restart the sequence
    run_bist(5, 3000, cyc, b1);
    check("rerun_latency", cyc, 15);
    check("rerun_err", {16'd0, err_cnt}, 0);
    check_writes("rerun");

    // Slave never accepts the write address
    hold_aw = 1'b1;
    @(negedge clk);
    start = 1'b1;
    n = 0;
    do begin @(negedge clk); start = 1'b0; n++; end while (aw_vld !== 1'b1 && n < 10);
    check("hang_aw_up", {31'd0, aw_vld}, 1);
`ifdef AXI_BIST_TIMEOUT_EN
    n = 0;
    while (done !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    check("wd_latency", n, 4096);
    check("wd_timeout", {31'd0, timeout}, 1);
    check("wd_err", {16'd0, err_cnt}, 1);
    check("wd_aw_dropped", {31'd0, aw_vld}, 0);
    hold_aw = 1'b0;
    run_bist(0, 3000, cyc, b1);
    check("wd_cleared", {31'd0, timeout}, 0);
    check("wd_after_err", {16'd0, err_cnt}, 0);
`else
    repeat (200) @(negedge clk);
    check("hang_done", {31'd0, done}, 0);
    check("hang_busy", {31'd0, busy}, 1);
    check("hang_aw_held", {31'd0, aw_vld}, 1);
    check("hang_addr", aw_addr, BASE);
    check("hang_timeout", {31'd0, timeout}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hold_aw = 1'b0;
    run_bist(0, 3000, cyc, b1);
    check("recover_latency", cyc, 15);
    check("recover_err", {16'd0, err_cnt}, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
